// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU datapath.
//   DATA_W            - datapath word width
//   word_t            - one datapath word
//   SEL_IN1 / SEL_IN2 - two-way operand select encodings
package cpu_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage : cpu_pkg

// File: rtl/dff_rst.sv
// dff_rst: WIDTH-bit datapath register, loaded on every rising clock edge,
// asynchronously forced to RESET_VAL while rst_n is low.
// Ports:
//   clk   - system clock, rising edge active
//   rst_n - asynchronous active-low reset
//   d     - next value, captured every rising edge
//   q     - registered value
module dff_rst
  import cpu_pkg::*;
#(
  parameter int                WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // State register: no enable, reset wins over the clock immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule : dff_rst

// File: rtl/mux_a.sv
// mux_a: registered 2:1 operand select for the ALU A-side operand.
// The combinational pick (sel ? in2 : in1) is captured on every rising
// clock edge, so outA only ever changes just after an edge or on reset.
// Ports:
//   clk   - system clock, rising edge active
//   rst_n - asynchronous active-low reset (outA <= RESET_VAL at once)
//   sel   - source select: SEL_IN1 picks in1, SEL_IN2 picks in2
//   in1   - operand source 0
//   in2   - operand source 1
//   outA  - registered selected operand, one cycle latency
module mux_a
  import cpu_pkg::*;
#(
  parameter int                WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] outA
);

  logic [WIDTH-1:0] next_s;

  // Source select; an unknown select deliberately yields X rather than
  // silently favouring one source, so a bad sel is visible downstream.
  always_comb begin
    next_s = {WIDTH{1'bx}};
    case (sel)
      SEL_IN1: next_s = in1;
      SEL_IN2: next_s = in2;
      default: next_s = {WIDTH{1'bx}};
    endcase
  end

  dff_rst #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_outa_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (next_s),
    .q     (outA)
  );

endmodule : mux_a

// File: tb/tb_mux_a.sv
// tb_mux_a: directed self-checking bench for mux_a.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after a rising edge, or mid-cycle where hold behaviour is being checked.
module tb_mux_a;
  import cpu_pkg::*;

  logic  clk;
  logic  rst_n;
  logic  sel;
  word_t in1;
  word_t in2;
  word_t outA;

  int n_checks;
  int n_fail;

  mux_a dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .in1   (in1),
    .in2   (in2),
    .outA  (outA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is short; never let the run hang.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: outA=%h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Wait for the next rising edge and step just past it.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    word_t exp_v;
    n_checks = 0;
    n_fail   = 0;
    sel = 1'b0;
    in1 = 16'h0001;
    in2 = 16'h0010;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_eq("reset_assert", outA, 16'h0000);

    // Reset held: sel toggling must not disturb outA.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel = ~sel;
      after_edge();
      check_eq("reset_hold", outA, 16'h0000);
    end

    // Release with sel=0; no change until the next rising edge.
    @(negedge clk);
    sel   = SEL_IN1;
    rst_n = 1'b1;
    #1 check_eq("release_no_change", outA, 16'h0000);
    after_edge();
    check_eq("sel_in1_first", outA, 16'h0001);

    // Mid-cycle change of in1 is not seen until the following edge.
    @(negedge clk);
    in1 = 16'h0010;
    #2 check_eq("in1_mid_hold", outA, 16'h0001);
    after_edge();
    check_eq("in1_updated", outA, 16'h0010);

    // Select in2.
    @(negedge clk);
    sel = SEL_IN2;
    in2 = 16'h0011;
    in1 = 16'h0010;
    #1 check_eq("sel_in2_hold", outA, 16'h0010);
    after_edge();
    check_eq("sel_in2", outA, 16'h0011);

    // Alternation with glitches on sel between edges.
    in1 = 16'hAAAA;
    in2 = 16'h5555;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sel = i[0];
      #1 sel = ~sel;
      #1 sel = ~sel;
      exp_v = i[0] ? 16'h5555 : 16'hAAAA;
      after_edge();
      check_eq("alternate", outA, exp_v);
      #2 sel = ~sel;
      #1 check_eq("alternate_glitch_hold", outA, exp_v);
      sel = ~sel;
    end

    // Async reset mid-run.
    @(negedge clk);
    sel = SEL_IN2;
    in2 = 16'h0011;
    after_edge();
    check_eq("pre_reset_value", outA, 16'h0011);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_immediate", outA, 16'h0000);
    after_edge();
    check_eq("async_reset_held", outA, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    sel   = SEL_IN1;
    in1   = 16'h0001;
    after_edge();
    check_eq("post_reset_load", outA, 16'h0001);

    // Boundary data: full-width words.
    @(negedge clk);
    in1 = 16'hFFFF;
    in2 = 16'h0000;
    sel = SEL_IN1;
    after_edge();
    check_eq("boundary_ffff", outA, 16'hFFFF);
    @(negedge clk);
    sel = SEL_IN2;
    after_edge();
    check_eq("boundary_0000", outA, 16'h0000);
    @(negedge clk);
    in2 = 16'h8001;
    after_edge();
    check_eq("boundary_8001", outA, 16'h8001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_a
